// File: rtl/adder_32bit_arb_seq_if.sv
// Request/response bundle for the two-requester sequenced adder.
// The slave modport is the adder side; the master modport is the requester/consumer side.
interface adder_32bit_arb_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface

// File: rtl/adder_32bit_arb_seq.sv
// Round-robin arbiter in front of a sequenced adder: one SLICE-bit slice per cycle,
// with a registered carry rippling between slices, and a valid/ready response port.
module adder_32bit_arb_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 16
) (
    input logic                  clk,
    input logic                  rst,
    adder_32bit_arb_seq_if.slave bus
);

    localparam int unsigned NS   = WIDTH / SLICE;
    localparam int unsigned IdxW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             rr_ptr_q;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             id_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             last_slice;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE:0]   slice_res;

    // Contention goes to rr_ptr; a lone requester always wins.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || rr_ptr_q);
        accept = (state_q == StIdle) && !rst && (grant0 || grant1);
    end

    assign slice_a    = a_q[idx_q * SLICE +: SLICE];
    assign slice_b    = b_q[idx_q * SLICE +: SLICE];
    assign slice_res  = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
    assign last_slice = (idx_q == LastIdx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (last_slice) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.req0_ready = grant0 && !rst;
                bus.req1_ready = grant1 && !rst;
            end
            StCalc: ;
            StDone: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_sum  = sum_q;
    assign bus.rsp_cout = cout_q;
    assign bus.rsp_id   = id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            id_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= grant1 ? bus.req1_a : bus.req0_a;
                b_q      <= grant1 ? bus.req1_b : bus.req0_b;
                id_q     <= grant1;
                rr_ptr_q <= !grant1;
                carry_q  <= 1'b0;
                idx_q    <= '0;
            end
            if (state_q == StCalc) begin
                sum_q[idx_q * SLICE +: SLICE] <= slice_res[SLICE-1:0];
                carry_q                       <= slice_res[SLICE];
                idx_q                         <= idx_q + IdxW'(1);
                if (last_slice) begin
                    cout_q <= slice_res[SLICE];
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_32bit_arb_seq.sv
// Directed and random checks for the arbitrated, slice-sequenced 32-bit adder.
module tb_adder_32bit_arb_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_32bit_arb_seq_if #(.WIDTH(32)) bus ();

    adder_32bit_arb_seq #(
        .WIDTH(32),
        .SLICE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    // Single operation on one port; checks 2-cycle latency, result and id.
    task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_sum, input bit exp_cout, input string name);
        int cyc;
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        cyc = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc >= 20) begin
            errors++;
            $display("FAIL %s accept: ready never rose within %0d cycles", name, cyc);
            clear_inputs();
            return;
        end
        step();
        // Scramble operands after acceptance; the in-flight op must not see this.
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = ~a; bus.req0_b = ~b; bus.req1_a = ~a; bus.req1_b = ~b;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_t0: rsp_valid=%b required 0", name, bus.rsp_valid);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_t1: rsp_valid=%b required 0", name, bus.rsp_valid);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency_t2: rsp_valid=%b required 1", name, bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_cout, bus.rsp_sum} !== {exp_cout, exp_sum}) begin
            errors++;
            $display("FAIL %s result: cout=%b sum=%h required cout=%b sum=%h", name,
                     bus.rsp_cout, bus.rsp_sum, exp_cout, exp_sum);
        end
        checks++;
        if (bus.rsp_id !== id) begin
            errors++;
            $display("FAIL %s id: rsp_id=%b required %b", name, bus.rsp_id, id);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_drop: rsp_valid=%b required 0", name, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: ready0/1=%b%b required 00", bus.req0_ready,
                     bus.req1_ready);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum} !== 35'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b cout=%b id=%b sum=%h required all 0",
                     bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum);
        end
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_rrptr: ready0/1=%b%b required 10", bus.req0_ready,
                     bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_wraparound();
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, "wrap");
    endtask

    task automatic test_slice_carry();
        do_op(1'b1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, "slice_carry");
    endtask

    task automatic test_arbitration();
        int  nrsp;
        bit  g0, g1;
        bit  ids [2];
        logic [31:0] exp_sum;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd1;  bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd10; bus.req1_b = 32'd20;
        bus.rsp_ready  = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 30 && nrsp < 2; c++) begin
            #1;
            checks++;
            if (bus.req0_ready && bus.req1_ready) begin
                errors++;
                $display("FAIL arb_onehot: ready0/1=11 required at most one high");
            end
            g0 = bus.req0_ready;
            g1 = bus.req1_ready;
            if (bus.rsp_valid === 1'b1) begin
                ids[nrsp] = bus.rsp_id;
                exp_sum   = bus.rsp_id ? 32'd30 : 32'd3;
                checks++;
                if (bus.rsp_sum !== exp_sum) begin
                    errors++;
                    $display("FAIL arb_sum: sum=%h required %h", bus.rsp_sum, exp_sum);
                end
                nrsp++;
            end
            step();
            if (g0) bus.req0_valid = 1'b0;
            if (g1) bus.req1_valid = 1'b0;
        end
        checks++;
        if (nrsp != 2) begin
            errors++;
            $display("FAIL arb_count: responses=%0d required 2", nrsp);
        end else begin
            checks++;
            if ({ids[0], ids[1]} !== 2'b01) begin
                errors++;
                $display("FAIL arb_order: ids=%b%b required 01", ids[0], ids[1]);
            end
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_stall();
        int cyc;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
        #1;
        cyc = 0;
        while (!bus.req0_ready && cyc < 20) begin step(); cyc++; end
        step();
        bus.req0_valid = 1'b0;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 10) begin step(); cyc++; end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_reach_done: rsp_valid=%b required 1", bus.rsp_valid);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum} !==
                {1'b1, 1'b0, 1'b0, 32'd12}) begin
                errors++;
                $display("FAIL stall_hold: valid=%b cout=%b id=%b sum=%h required 1 0 0 0000000c",
                         bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_sum);
            end
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready: ready0/1=%b%b required 00", bus.req0_ready,
                         bus.req1_ready);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rsp_valid=%b required 0", bus.rsp_valid);
        end
        // rr_ptr moved to 1 after serving req0, so req1 wins the contention.
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_idle_ready: ready0/1=%b%b required 01", bus.req0_ready,
                     bus.req1_ready);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_reset_mid_calc();
        int cyc;
        bus.req0_valid = 1'b1; bus.req0_a = 32'h8000_0000; bus.req0_b = 32'h8000_0000;
        #1;
        cyc = 0;
        while (!bus.req0_ready && cyc < 20) begin step(); cyc++; end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_ready: ready0/1=%b%b required 00", bus.req0_ready,
                     bus.req1_ready);
        end
        #1;
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_norsp: rsp_valid=%b required 0 (cycle %0d)",
                         bus.rsp_valid, i);
            end
            step();
        end
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "retry");
    endtask

    task automatic test_back_to_back();
        logic [33:0] expq [$];
        logic [33:0] exp;
        int  ops_done;
        int  cycles;
        bit  g0, g1;
        bit  have_prev;
        bit  prev_id;
        ops_done  = 0;
        cycles    = 0;
        have_prev = 1'b0;
        prev_id   = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = $urandom(); bus.req0_b = $urandom();
        bus.req1_valid = 1'b1; bus.req1_a = $urandom(); bus.req1_b = $urandom();
        while (ops_done < 1000 && cycles < 20000) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g0 = bus.req0_ready;
            g1 = bus.req1_ready;
            if (g0) expq.push_back({1'b0, {1'b0, bus.req0_a} + {1'b0, bus.req0_b}});
            if (g1) expq.push_back({1'b1, {1'b0, bus.req1_a} + {1'b0, bus.req1_b}});
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: response id=%b with nothing pending",
                             bus.rsp_id);
                end else begin
                    exp = expq.pop_front();
                    if ({bus.rsp_id, bus.rsp_cout, bus.rsp_sum} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result op %0d: id=%b cout=%b sum=%h required id=%b cout=%b sum=%h",
                                 ops_done, bus.rsp_id, bus.rsp_cout, bus.rsp_sum,
                                 exp[33], exp[32], exp[31:0]);
                    end
                end
                if (have_prev) begin
                    checks++;
                    if (bus.rsp_id === prev_id) begin
                        errors++;
                        $display("FAIL b2b_alternate op %0d: id=%b required %b", ops_done,
                                 bus.rsp_id, !prev_id);
                    end
                end
                prev_id   = bus.rsp_id;
                have_prev = 1'b1;
                ops_done++;
            end
            step();
            if (g0) begin bus.req0_a = $urandom(); bus.req0_b = $urandom(); end
            if (g1) begin bus.req1_a = $urandom(); bus.req1_b = $urandom(); end
            cycles++;
        end
        clear_inputs();
        checks++;
        if (ops_done < 1000) begin
            errors++;
            $display("FAIL b2b_timeout: %0d ops completed required 1000", ops_done);
        end
        #1;
    endtask

    initial begin
        test_reset();
        test_wraparound();
        test_arbitration();
        test_slice_carry();
        test_stall();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
